// File: rtl/mac_pkg.sv
// Shared types for the MAC-chain feeder: FSM state encoding and width helper.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/feeder_buf.sv
// Circular operand buffer with a show-ahead head and wrap-bit pointers.
// Pushes to a full buffer and pops from an empty one are ignored.
module feeder_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int CNT_W     = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]      wptr;
  logic [CNT_W-1:0]      rptr;
  logic                  push_ok;
  logic                  pop_ok;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign count   = wptr - rptr;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (wptr == rptr);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + CNT_W'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vector_feeder.sv
// Source end of the MAC chain: buffers (A,B) pairs, then clears the chain, streams B beats,
// serves A reads on demand and pulses done once the downstream result has settled.
module vector_feeder
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int MAC_LAT    = 2,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_a,
  input  logic [DATA_WIDTH-1:0] i_wr_b,
  input  logic                  i_start,
  input  logic [CNT_W-1:0]      i_len,
  output logic                  o_full,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_clr,
  output logic                  o_b_valid,
  output logic [DATA_WIDTH-1:0] o_b,
  input  logic                  i_a_rden,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic                  o_a_err
);

  localparam int DR_W = cnt_width(MAC_LAT);

  feeder_state_t         state;
  feeder_state_t         state_nxt;
  logic [CNT_W-1:0]      n_len;
  logic [CNT_W-1:0]      issued;
  logic [DR_W-1:0]       drain_cnt;
  logic                  issue;
  logic                  latch;
  logic                  wr_ok;
  logic                  b_valid_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  a_err_q;

  logic [DATA_WIDTH-1:0] a_head;
  logic [CNT_W-1:0]      a_count_unused;
  logic                  a_full;
  logic                  a_empty;
  logic [DATA_WIDTH-1:0] b_head;
  logic [CNT_W-1:0]      b_count;
  logic                  b_full;
  logic                  b_empty_unused;

  assign o_full  = a_full || b_full;
  assign o_count = b_count;
  assign wr_ok   = i_wr_en && (state == IDLE) && !o_full;

  feeder_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_a_buf (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (wr_ok),
    .wr_data (i_wr_a),
    .pop     (i_a_rden),
    .head    (a_head),
    .count   (a_count_unused),
    .full    (a_full),
    .empty   (a_empty)
  );

  feeder_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_b_buf (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (wr_ok),
    .wr_data (i_wr_b),
    .pop     (issue),
    .head    (b_head),
    .count   (b_count),
    .full    (b_full),
    .empty   (b_empty_unused)
  );

  // A beat is issued on the clock edge that ends CLR and on each STREAM edge until n are out,
  // so the registered o_b_valid covers exactly the n STREAM cycles.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          latch     = 1'b1;
          state_nxt = CLR;
        end
      end
      CLR: begin
        if (n_len == '0) begin
          state_nxt = DRAIN;
        end else begin
          issue     = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (issued < n_len) begin
          issue = 1'b1;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DR_W'(MAC_LAT - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      n_len     <= '0;
      issued    <= '0;
      drain_cnt <= '0;
      b_valid_q <= 1'b0;
      b_q       <= '0;
      a_err_q   <= 1'b0;
    end else begin
      if (latch) begin
        // Only B beats are guaranteed present; A alignment is left to the consumer.
        n_len  <= (i_len < b_count) ? i_len : b_count;
        issued <= '0;
      end else if (issue) begin
        issued <= issued + CNT_W'(1);
      end

      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DR_W'(1);
      end else begin
        drain_cnt <= '0;
      end

      b_valid_q <= issue;
      if (issue) begin
        b_q <= b_head;
      end

      if (i_a_rden && a_empty) begin
        a_err_q <= 1'b1;
      end
    end
  end

  assign o_busy    = (state != IDLE);
  assign o_clr     = (state == CLR);
  assign o_done    = (state == DONE);
  assign o_b_valid = b_valid_q;
  assign o_b       = b_q;
  assign o_a       = a_empty ? '0 : a_head;
  assign o_a_err   = a_err_q;

endmodule

// File: tb/tb_vector_feeder.sv
// Directed and randomized checks of vector_feeder against a queue-based pair model.
module tb_vector_feeder;

  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int MAC_LAT = 2;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [DW-1:0]    wr_a;
  logic [DW-1:0]    wr_b;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             clr;
  logic             b_valid;
  logic [DW-1:0]    b;
  logic [DW-1:0]    a;
  logic             a_err;
  logic             manual_rden;
  logic             follow;
  logic             a_rden;

  // Behavioural consumer: reads A alongside every B beat it receives.
  assign a_rden = manual_rden || (follow && b_valid);

  vector_feeder #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .MAC_LAT    (MAC_LAT)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (wr_en),
    .i_wr_a    (wr_a),
    .i_wr_b    (wr_b),
    .i_start   (start),
    .i_len     (len),
    .o_full    (full),
    .o_count   (count),
    .o_busy    (busy),
    .o_done    (done),
    .o_clr     (clr),
    .o_b_valid (b_valid),
    .o_b       (b),
    .i_a_rden  (a_rden),
    .o_a       (a),
    .o_a_err   (a_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           log_bc[$];
  int unsigned  log_b[$];
  int unsigned  log_a[$];
  int           log_clr[$];
  int           log_done[$];

  always @(negedge clk) begin
    if (b_valid) begin
      log_b.push_back(int'(b));
      log_a.push_back(int'(a));
      log_bc.push_back(cyc);
    end
    if (clr)  log_clr.push_back(cyc);
    if (done) log_done.push_back(cyc);
  end

  int errors = 0;
  int checks = 0;
  byte unsigned qa[$];
  byte unsigned qb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic write_pair(input int va, input int vb);
    wr_en = 1'b1;
    wr_a  = DW'(va);
    wr_b  = DW'(vb);
    tick();
    wr_en = 1'b0;
    if (qb.size() < DEPTH) begin
      qa.push_back(byte'(va));
      qb.push_back(byte'(vb));
    end
  endtask

  task automatic run_pass(input string tag, input int plen, output int unsigned acc_out);
    int nb, nc, nd, n, t;
    int unsigned exp_acc, got_acc;
    byte unsigned eb[$];
    nb = log_b.size();
    nc = log_clr.size();
    nd = log_done.size();
    n  = (plen < qb.size()) ? plen : qb.size();
    exp_acc = 0;
    for (int i = 0; i < n; i++) begin
      eb.push_back(qb[i]);
      exp_acc += int'(qa[i]) * int'(qb[i]);
    end
    start = 1'b1;
    len   = CNT_W'(plen);
    @(posedge clk);
    #1;
    t     = cyc;
    start = 1'b0;
    for (int k = 0; k < 100 && log_done.size() == nd; k++) tick();
    for (int k = 0; k < 3; k++) tick();
    check({tag, " done_pulses"}, log_done.size() - nd, 1);
    check({tag, " clr_pulses"}, log_clr.size() - nc, 1);
    check({tag, " clr_cycle"}, log_clr[nc] - t, 0);
    check({tag, " done_cycle"}, log_done[nd] - t, 1 + n + MAC_LAT);
    check({tag, " beats"}, log_b.size() - nb, n);
    if (n > 0) begin
      check({tag, " first_beat_cycle"}, log_bc[nb] - t, 1);
      check({tag, " last_beat_cycle"}, log_bc[nb + n - 1] - t, n);
    end
    got_acc = 0;
    for (int i = 0; i < n; i++) begin
      check({tag, " b_data"}, log_b[nb + i], eb[i]);
      got_acc += log_a[nb + i] * log_b[nb + i];
    end
    check({tag, " acc"}, got_acc, exp_acc);
    for (int i = 0; i < n; i++) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    check({tag, " count_after"}, count, qb.size());
    check({tag, " busy_after"}, busy, 0);
    acc_out = got_acc;
  endtask

  initial begin
    int unsigned acc;
    int nd, nb;
    rst = 1'b1; wr_en = 1'b0; wr_a = '0; wr_b = '0; start = 1'b0; len = '0;
    manual_rden = 1'b0; follow = 1'b1;
    tick(); tick();
    check("reset_outputs", {full, count, busy, done, clr, b_valid, b, a, a_err}, 0);
    rst = 1'b0;
    tick();

    // 1: nine pairs (k,k), full pass, sum of squares downstream
    for (int k = 1; k <= 9; k++) write_pair(k, k);
    check("t1 count_loaded", count, 9);
    run_pass("t1", 9, acc);
    check("t1 acc_285", acc, 285);

    // 2: zero-length pass leaves buffers untouched
    for (int k = 0; k < 3; k++) write_pair($urandom_range(0, 255), $urandom_range(0, 255));
    run_pass("t2", 0, acc);
    check("t2 count_kept", count, 3);

    // 3: partial pass moves pointers, then fill to capacity across the wrap
    run_pass("t3a", 3, acc);
    for (int k = 0; k < 16; k++) write_pair($urandom_range(0, 255), $urandom_range(0, 255));
    check("t3 full_at_16", full, 1);
    check("t3 count_16", count, 16);
    write_pair(8'hAA, 8'h55);
    check("t3 count_after_drop", count, 16);
    run_pass("t3b", 16, acc);
    check("t3 empty_after", full, 0);

    // 4: request longer than buffered
    for (int k = 0; k < 5; k++) write_pair($urandom_range(0, 255), $urandom_range(0, 255));
    run_pass("t4", 20, acc);

    // random passes
    for (int r = 0; r < 3; r++) begin
      int nw;
      nw = $urandom_range(1, 10);
      for (int k = 0; k < nw; k++) write_pair($urandom_range(0, 255), $urandom_range(0, 255));
      run_pass("rnd", $urandom_range(0, 12), acc);
    end

    // 5: reset during a pass
    for (int k = 0; k < 8; k++) write_pair($urandom_range(0, 255), $urandom_range(0, 255));
    nd = log_done.size();
    nb = log_b.size();
    start = 1'b1;
    len   = CNT_W'(8);
    tick();
    start = 1'b0;
    for (int k = 0; k < 50 && log_b.size() < nb + 3; k++) tick();
    check("t5 three_beats_seen", log_b.size() - nb, 3);
    rst = 1'b1;
    tick();
    check("t5 valid_dropped", b_valid, 0);
    check("t5 count_cleared", count, 0);
    check("t5 busy_cleared", busy, 0);
    rst = 1'b0;
    qa.delete();
    qb.delete();
    for (int k = 0; k < 12; k++) tick();
    check("t5 no_done", log_done.size() - nd, 0);
    check("t5 no_more_beats", log_b.size() - nb, 3);

    // 6: read request on empty A is sticky until reset
    check("t6 err_before", a_err, 0);
    manual_rden = 1'b1;
    tick();
    manual_rden = 1'b0;
    tick();
    check("t6 err_set", a_err, 1);
    for (int k = 0; k < 4; k++) write_pair($urandom_range(0, 255), $urandom_range(0, 255));
    run_pass("t6", 4, acc);
    check("t6 err_held", a_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("t6 err_cleared", a_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
